multicycle_ctrl_p: RTL and testbench
====================================

# multicycle_ctrl_p

Parametrised multi-cycle control unit for the accumulator/register-file datapath: sequences fetch, decode, ALU, move, immediate, memory load/store and conditional jump instructions. It adds a memory-ready handshake with timeout, internal branch-condition evaluation, halt/illegal-opcode handling and a retired-instruction counter. It sits beside the datapath, driving all load enables, write enables and mux selects from the 4-bit opcode and the CZN flags.

## Interface
- MEM_HANDSHAKE, 1, 1: memory states wait for mem_ready; 0: memory is single-cycle and mem_ready is ignored
- TIMEOUT_W, 4, width of the memory-wait counter
- MEM_TIMEOUT, 15, wait cycles allowed before bus error (≤ 2^TIMEOUT_W−1)
- CNT_W, 16, width of the retired-instruction counter

- clk  in  1  single clock, rising edge
- rst  in  1  reset: synchronous, active-low
- instruction  in  4  opcode bits IR[15:12]
- flag_c, flag_z, flag_n  in  1 each  CZN register outputs
- mem_ready  in  1  memory access completes this cycle
- ld_PC, ld_IR, ld_DI, ld_TR, ld_ALU, ld_CZN, write_en_rf  out  1 each  datapath load/write enables
- MEM_read, MEM_write  out  1  memory strobes
- sel_MEM_src  out  1  0 = PC, 1 = TR
- sel_RF_wsrc  out  2  rf_wsrc_t: ALU, REG1, MEM, DI
- sel_PC_src_jump  out  1  PC loads jump target instead of PC+1
- sel_ALU_src_reg1  out  1  ALU operand B from reg1
- halted  out  1  HLT retired; sticky until reset
- bus_err  out  1  memory timeout; sticky until reset
- illegal  out  1  undefined opcode decoded; sticky until reset
- retired  out  CNT_W  retired instruction count, wraps modulo 2^CNT_W

## Operation
- Opcodes: LDI 000x; MVR 0010; ADR 0011; ANR 0100; ORR 0101; LDM 1000; STM 1001; JMP 1100; JZ 1101; JC 1110; HLT 1111; all others illegal.
- States: IF, DEC, LDI, MVR, ALU, ALU_WB, MADDR, LDM_RD, LDM_WB, STM_WR, JMP, HALT, ERR.
- IF: MEM_read=1, sel_MEM_src=PC. ld_IR=ld_PC=1 only in the cycle mem_ready=1 (or always if MEM_HANDSHAKE=0), then → DEC.
- DEC: no outputs; branch on opcode. Illegal sets illegal and → IF; the instruction is not counted.
- LDI: ld_DI=1 → IF.
- MVR: write_en_rf, sel_RF_wsrc=REG1, ld_CZN → IF.
- ALU: ld_ALU, sel_ALU_src_reg1, ld_CZN → ALU_WB (write_en_rf, sel_RF_wsrc=ALU) → IF.
- LDM/STM: MADDR (ld_TR) → LDM_RD (MEM_read, sel_MEM_src=TR, wait) → LDM_WB (write_en_rf, sel_RF_wsrc=MEM) → IF; or → STM_WR (MEM_write, sel_MEM_src=TR, held until mem_ready) → IF.
- JMP/JZ/JC: JMP state; ld_PC=sel_PC_src_jump=1 iff op=JMP, or JZ & flag_z, or JC & flag_c. Flags are sampled in that cycle. → IF.
- HLT: → HALT; halted=1, all strobes 0, HALT is absorbing.
- Wait counter: cleared on entry to any memory state and incremented each cycle mem_ready=0. When it reaches MEM_TIMEOUT without mem_ready: set bus_err → ERR (absorbing, all outputs 0).
- retired increments by 1 on the final cycle of each legal instruction, including HLT on its entry to HALT.

## Timing
- Outputs are Moore decodes of state; the only exception is ld_IR/ld_PC in IF, which is gated by mem_ready.
- Zero-wait cycle counts: LDI/MVR/JMP-class 3; ALU 4; STM 4; LDM 5.
- Each memory wait cycle adds exactly 1 cycle. mem_ready arriving on the timeout cycle wins; no error is raised.
- Reset (rst=0 at a clock edge, at any time including mid-access or in HALT/ERR):
  - state=IF; counters=0; halted=bus_err=illegal=0.
  - In the first cycle after reset only the IF outputs are active: MEM_read=1, sel_MEM_src=PC.
- Exactly one next-state logic block; no sensitivity to instruction outside DEC.

## Structure
- Package ctrl_pkg: opcode constants, state_t enum, rf_wsrc_t enum, mem_src_t.
- One sub-module, mem_wait_timer (counter, clear, timeout compare), instantiated once.

## Test plan
- Reset, then ADR with mem_ready tied high → IF, DEC, ALU, ALU_WB, IF; write_en_rf only in ALU_WB; retired=1.
- LDM with mem_ready low 3 cycles in LDM_RD → MEM_read held 4 cycles; LDM_WB one cycle later; total 8 cycles.
- JZ with flag_z=0 then JZ with flag_z=1 → ld_PC=0 in JMP, then ld_PC=sel_PC_src_jump=1.
- mem_ready held low in IF, MEM_TIMEOUT=15 → bus_err rises after 15 wait cycles; ERR holds; rst=0 clears it.
- Opcode 0111 → illegal=1, back to IF after DEC, retired unchanged; HLT → halted=1, no further strobes.
- rst=0 asserted in STM_WR → next cycle state IF, MEM_write=0, retired=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller.
// Contents:
//   - opcode constants for IR[15:12]
//   - state_t:   controller FSM states
//   - rf_wsrc_t: register-file write-source select
//   - mem_src_t: memory address source select
//   - is_mem_state(): true for states that wait on a memory handshake
package ctrl_pkg;

  // LDI ignores the opcode LSB, so both encodings are listed.
  localparam logic [3:0] OpLdi0 = 4'b0000;
  localparam logic [3:0] OpLdi1 = 4'b0001;
  localparam logic [3:0] OpMvr  = 4'b0010;
  localparam logic [3:0] OpAdr  = 4'b0011;
  localparam logic [3:0] OpAnr  = 4'b0100;
  localparam logic [3:0] OpOrr  = 4'b0101;
  localparam logic [3:0] OpLdm  = 4'b1000;
  localparam logic [3:0] OpStm  = 4'b1001;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpJz   = 4'b1101;
  localparam logic [3:0] OpJc   = 4'b1110;
  localparam logic [3:0] OpHlt  = 4'b1111;

  typedef enum logic [3:0] {
    StIf, StDec, StLdi, StMvr, StAlu, StAluWb, StMaddr,
    StLdmRd, StLdmWb, StStmWr, StJmp, StHalt, StErr
  } state_t;

  typedef enum logic [1:0] {
    RfWsrcAlu  = 2'd0,
    RfWsrcReg1 = 2'd1,
    RfWsrcMem  = 2'd2,
    RfWsrcDi   = 2'd3
  } rf_wsrc_t;

  typedef enum logic {
    MemSrcPc = 1'b0,
    MemSrcTr = 1'b1
  } mem_src_t;

  function automatic logic is_mem_state(state_t s);
    return (s == StIf) || (s == StLdmRd) || (s == StStmWr);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait-cycle counter.
// Counts consecutive cycles a memory access is stalled and flags when the
// count has reached MEM_TIMEOUT.
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   i_clr     clear the count to zero (wins over i_inc)
//   i_inc     one more wait cycle elapsed
//   o_timeout count equals MEM_TIMEOUT
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_W   = 4,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_timeout
);

  logic [TIMEOUT_W-1:0] r_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt_q <= '0;
    end else if (i_clr) begin
      r_cnt_q <= '0;
    end else if (i_inc) begin
      r_cnt_q <= r_cnt_q + 1'b1;
    end
  end

  assign o_timeout = (r_cnt_q == TIMEOUT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_p.sv
// Multi-cycle control unit for the accumulator/register-file datapath.
// Sequences fetch/decode/execute, waits on the memory handshake with a
// timeout, evaluates branch conditions, and tracks retired instructions.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   instruction                   opcode IR[15:12], only looked at in DEC
//   flag_c/flag_z/flag_n          CZN flags, sampled in the JMP state
//   mem_ready                     memory access completes this cycle
//   ld_*/write_en_rf              datapath load/write enables
//   MEM_read/MEM_write            memory strobes
//   sel_MEM_src/sel_RF_wsrc/
//   sel_PC_src_jump/sel_ALU_src_reg1  datapath mux selects
//   halted/bus_err/illegal        sticky status until reset
//   retired                       retired instruction count (wraps)
module multicycle_ctrl_p
  import ctrl_pkg::*;
#(
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned TIMEOUT_W     = 4,
  parameter int unsigned MEM_TIMEOUT   = 15,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       instruction,
  input  logic             flag_c,
  input  logic             flag_z,
  input  logic             flag_n,
  input  logic             mem_ready,
  output logic             ld_PC,
  output logic             ld_IR,
  output logic             ld_DI,
  output logic             ld_TR,
  output logic             ld_ALU,
  output logic             ld_CZN,
  output logic             write_en_rf,
  output logic             MEM_read,
  output logic             MEM_write,
  output logic             sel_MEM_src,
  output logic [1:0]       sel_RF_wsrc,
  output logic             sel_PC_src_jump,
  output logic             sel_ALU_src_reg1,
  output logic             halted,
  output logic             bus_err,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state_q, w_state_d;
  logic [3:0]       r_op_q;
  logic             r_illegal_q;
  logic [CNT_W-1:0] r_retired_q;

  logic     w_mem_rdy, w_wait, w_timeout, w_take, w_retire, w_set_ill, w_flag_n_unused;
  rf_wsrc_t w_wsrc;
  mem_src_t w_mem_src;

  // Without the handshake every memory access completes in one cycle.
  assign w_mem_rdy = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;
  assign w_wait    = is_mem_state(r_state_q) && !w_mem_rdy;

  // Holding the count at zero outside stalls guarantees it is zero on entry
  // to every memory state.
  mem_wait_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_wait),
    .i_inc    (w_wait),
    .o_timeout(w_timeout)
  );

  assign w_take = (r_op_q == OpJmp) || ((r_op_q == OpJz) && flag_z) ||
                  ((r_op_q == OpJc) && flag_c);
  assign w_flag_n_unused = flag_n;

  always_comb begin
    w_state_d        = r_state_q;
    ld_PC            = 1'b0;
    ld_IR            = 1'b0;
    ld_DI            = 1'b0;
    ld_TR            = 1'b0;
    ld_ALU           = 1'b0;
    ld_CZN           = 1'b0;
    write_en_rf      = 1'b0;
    MEM_read         = 1'b0;
    MEM_write        = 1'b0;
    sel_PC_src_jump  = 1'b0;
    sel_ALU_src_reg1 = 1'b0;
    w_wsrc           = RfWsrcAlu;
    w_mem_src        = MemSrcPc;
    w_retire         = 1'b0;
    w_set_ill        = 1'b0;

    unique case (r_state_q)
      StIf: begin
        MEM_read = 1'b1;
        if (w_mem_rdy) begin
          ld_IR     = 1'b1;
          ld_PC     = 1'b1;
          w_state_d = StDec;
        end else if (w_timeout) begin
          w_state_d = StErr;
        end
      end
      StDec: begin
        case (instruction)
          OpLdi0, OpLdi1:      w_state_d = StLdi;
          OpMvr:               w_state_d = StMvr;
          OpAdr, OpAnr, OpOrr: w_state_d = StAlu;
          OpLdm, OpStm:        w_state_d = StMaddr;
          OpJmp, OpJz, OpJc:   w_state_d = StJmp;
          OpHlt: begin
            w_state_d = StHalt;
            w_retire  = 1'b1;
          end
          default: begin
            w_set_ill = 1'b1;
            w_state_d = StIf;
          end
        endcase
      end
      StLdi: begin
        ld_DI     = 1'b1;
        w_retire  = 1'b1;
        w_state_d = StIf;
      end
      StMvr: begin
        write_en_rf = 1'b1;
        w_wsrc      = RfWsrcReg1;
        ld_CZN      = 1'b1;
        w_retire    = 1'b1;
        w_state_d   = StIf;
      end
      StAlu: begin
        ld_ALU           = 1'b1;
        sel_ALU_src_reg1 = 1'b1;
        ld_CZN           = 1'b1;
        w_state_d        = StAluWb;
      end
      StAluWb: begin
        write_en_rf = 1'b1;
        w_wsrc      = RfWsrcAlu;
        w_retire    = 1'b1;
        w_state_d   = StIf;
      end
      StMaddr: begin
        ld_TR     = 1'b1;
        w_state_d = (r_op_q == OpStm) ? StStmWr : StLdmRd;
      end
      StLdmRd: begin
        MEM_read  = 1'b1;
        w_mem_src = MemSrcTr;
        if (w_mem_rdy)      w_state_d = StLdmWb;
        else if (w_timeout) w_state_d = StErr;
      end
      StLdmWb: begin
        write_en_rf = 1'b1;
        w_wsrc      = RfWsrcMem;
        w_retire    = 1'b1;
        w_state_d   = StIf;
      end
      StStmWr: begin
        MEM_write = 1'b1;
        w_mem_src = MemSrcTr;
        if (w_mem_rdy) begin
          w_retire  = 1'b1;
          w_state_d = StIf;
        end else if (w_timeout) begin
          w_state_d = StErr;
        end
      end
      StJmp: begin
        ld_PC           = w_take;
        sel_PC_src_jump = w_take;
        w_retire        = 1'b1;
        w_state_d       = StIf;
      end
      StHalt:  w_state_d = StHalt;
      StErr:   w_state_d = StErr;
      default: w_state_d = StIf;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q   <= StIf;
      r_op_q      <= '0;
      r_illegal_q <= 1'b0;
      r_retired_q <= '0;
    end else begin
      r_state_q <= w_state_d;
      // Opcode is latched in DEC so later states never look at instruction.
      if (r_state_q == StDec) r_op_q <= instruction;
      if (w_set_ill)          r_illegal_q <= 1'b1;
      if (w_retire)           r_retired_q <= r_retired_q + 1'b1;
    end
  end

  assign sel_MEM_src = w_mem_src;
  assign sel_RF_wsrc = w_wsrc;
  assign halted      = (r_state_q == StHalt);
  assign bus_err     = (r_state_q == StErr);
  assign illegal     = r_illegal_q;
  assign retired     = r_retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_p.sv
// Directed bench for multicycle_ctrl_p: each step pushes the expected output
// vector and retired count to a scoreboard, then pops and compares it on the
// falling edge of that cycle.
module tb_multicycle_ctrl_p;

  localparam int unsigned CNT_W = 16;

  // Output vector bit positions (bit 0 spare).
  localparam logic [17:0] BLdPc  = 18'h1 << 17;
  localparam logic [17:0] BLdIr  = 18'h1 << 16;
  localparam logic [17:0] BLdDi  = 18'h1 << 15;
  localparam logic [17:0] BLdTr  = 18'h1 << 14;
  localparam logic [17:0] BLdAlu = 18'h1 << 13;
  localparam logic [17:0] BLdCzn = 18'h1 << 12;
  localparam logic [17:0] BWe    = 18'h1 << 11;
  localparam logic [17:0] BRd    = 18'h1 << 10;
  localparam logic [17:0] BWr    = 18'h1 << 9;
  localparam logic [17:0] BSrcTr = 18'h1 << 8;
  localparam logic [17:0] WReg1  = 18'h1 << 6;
  localparam logic [17:0] WMem   = 18'h2 << 6;
  localparam logic [17:0] BJsel  = 18'h1 << 5;
  localparam logic [17:0] BReg1  = 18'h1 << 4;
  localparam logic [17:0] BHalt  = 18'h1 << 3;
  localparam logic [17:0] BBerr  = 18'h1 << 2;
  localparam logic [17:0] BIll   = 18'h1 << 1;

  localparam logic [17:0] EIfRdy  = BRd | BLdPc | BLdIr;
  localparam logic [17:0] EIfWait = BRd;
  localparam logic [17:0] EDec    = 18'h0;
  localparam logic [17:0] ELdi    = BLdDi;
  localparam logic [17:0] EMvr    = BWe | WReg1 | BLdCzn;
  localparam logic [17:0] EAlu    = BLdAlu | BReg1 | BLdCzn;
  localparam logic [17:0] EAluWb  = BWe;
  localparam logic [17:0] EMaddr  = BLdTr;
  localparam logic [17:0] ELdmRd  = BRd | BSrcTr;
  localparam logic [17:0] ELdmWb  = BWe | WMem;
  localparam logic [17:0] EStmWr  = BWr | BSrcTr;
  localparam logic [17:0] EJmpT   = BLdPc | BJsel;
  localparam logic [17:0] EJmpN   = 18'h0;

  typedef struct {
    string            tag;
    logic [17:0]      o;
    logic [CNT_W-1:0] r;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] instruction;
  logic flag_c, flag_z, flag_n, mem_ready;
  logic ld_PC, ld_IR, ld_DI, ld_TR, ld_ALU, ld_CZN, write_en_rf;
  logic MEM_read, MEM_write, sel_MEM_src, sel_PC_src_jump, sel_ALU_src_reg1;
  logic halted, bus_err, illegal;
  logic [1:0] sel_RF_wsrc;
  logic [CNT_W-1:0] retired;
  logic [17:0] obs;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [17:0] sticky = '0;
  logic [CNT_W-1:0] ret = '0;

  always #5 clk = ~clk;

  multicycle_ctrl_p #(
    .MEM_HANDSHAKE(1),
    .TIMEOUT_W    (4),
    .MEM_TIMEOUT  (15),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .instruction     (instruction),
    .flag_c          (flag_c),
    .flag_z          (flag_z),
    .flag_n          (flag_n),
    .mem_ready       (mem_ready),
    .ld_PC           (ld_PC),
    .ld_IR           (ld_IR),
    .ld_DI           (ld_DI),
    .ld_TR           (ld_TR),
    .ld_ALU          (ld_ALU),
    .ld_CZN          (ld_CZN),
    .write_en_rf     (write_en_rf),
    .MEM_read        (MEM_read),
    .MEM_write       (MEM_write),
    .sel_MEM_src     (sel_MEM_src),
    .sel_RF_wsrc     (sel_RF_wsrc),
    .sel_PC_src_jump (sel_PC_src_jump),
    .sel_ALU_src_reg1(sel_ALU_src_reg1),
    .halted          (halted),
    .bus_err         (bus_err),
    .illegal         (illegal),
    .retired         (retired)
  );

  assign obs = {ld_PC, ld_IR, ld_DI, ld_TR, ld_ALU, ld_CZN, write_en_rf, MEM_read, MEM_write,
                sel_MEM_src, sel_RF_wsrc, sel_PC_src_jump, sel_ALU_src_reg1, halted, bus_err,
                illegal, 1'b0};

  // One clock cycle: queue the expectation, compare mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic [17:0] o_exp, input logic [CNT_W-1:0] r_exp);
    exp_t e;
    e.tag = tag;
    e.o   = o_exp | sticky;
    e.r   = r_exp;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (obs === e.o) else begin
      errors++;
      $error("FAIL %s outputs: got %h expected %h", e.tag, obs, e.o);
    end
    checks++;
    assert (retired === e.r) else begin
      errors++;
      $error("FAIL %s retired: got %0d expected %0d", e.tag, retired, e.r);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; instruction = 4'b0000; mem_ready = 1'b0;
    flag_c = 1'b0; flag_z = 1'b0; flag_n = 1'b0;
    @(posedge clk); #1;
    step("reset_if", EIfWait, '0);
    rst = 1'b1;

    // ADR, zero wait
    instruction = 4'b0011; mem_ready = 1'b1;
    step("adr_if", EIfRdy, ret);
    step("adr_dec", EDec, ret);
    step("adr_alu", EAlu, ret);
    step("adr_wb", EAluWb, ret);
    ret = ret + 1'b1;

    // LDM with three wait cycles in LDM_RD
    instruction = 4'b1000;
    step("ldm_if", EIfRdy, ret);
    step("ldm_dec", EDec, ret);
    step("ldm_maddr", EMaddr, ret);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("ldm_wait", ELdmRd, ret);
    mem_ready = 1'b1;
    step("ldm_rd", ELdmRd, ret);
    step("ldm_wb", ELdmWb, ret);
    ret = ret + 1'b1;

    // LDI (odd encoding) and MVR
    instruction = 4'b0001;
    step("ldi_if", EIfRdy, ret);
    step("ldi_dec", EDec, ret);
    step("ldi_ex", ELdi, ret);
    ret = ret + 1'b1;
    instruction = 4'b0010;
    step("mvr_if", EIfRdy, ret);
    step("mvr_dec", EDec, ret);
    step("mvr_ex", EMvr, ret);
    ret = ret + 1'b1;

    // Branches: JZ not taken, JZ taken, JC not taken, JC taken, JMP unconditional
    instruction = 4'b1101; flag_z = 1'b0;
    step("jz0_if", EIfRdy, ret); step("jz0_dec", EDec, ret); step("jz0_jmp", EJmpN, ret);
    ret = ret + 1'b1;
    flag_z = 1'b1;
    step("jz1_if", EIfRdy, ret); step("jz1_dec", EDec, ret); step("jz1_jmp", EJmpT, ret);
    ret = ret + 1'b1;
    instruction = 4'b1110; flag_c = 1'b0;
    step("jc0_if", EIfRdy, ret); step("jc0_dec", EDec, ret); step("jc0_jmp", EJmpN, ret);
    ret = ret + 1'b1;
    flag_c = 1'b1; flag_z = 1'b0;
    step("jc1_if", EIfRdy, ret); step("jc1_dec", EDec, ret); step("jc1_jmp", EJmpT, ret);
    ret = ret + 1'b1;
    instruction = 4'b1100; flag_c = 1'b0;
    step("jmp_if", EIfRdy, ret); step("jmp_dec", EDec, ret); step("jmp_jmp", EJmpT, ret);
    ret = ret + 1'b1;

    // STM with one wait cycle
    instruction = 4'b1001;
    step("stm_if", EIfRdy, ret);
    step("stm_dec", EDec, ret);
    step("stm_maddr", EMaddr, ret);
    mem_ready = 1'b0;
    step("stm_wait", EStmWr, ret);
    mem_ready = 1'b1;
    step("stm_wr", EStmWr, ret);
    ret = ret + 1'b1;

    // Illegal opcode: not counted, flag sticks
    instruction = 4'b0111;
    step("ill_if", EIfRdy, ret);
    step("ill_dec", EDec, ret);
    sticky = BIll;

    // mem_ready on the timeout cycle wins
    instruction = 4'b0000; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step("edge_wait", EIfWait, ret);
    mem_ready = 1'b1;
    step("edge_if", EIfRdy, ret);
    step("edge_dec", EDec, ret);
    step("edge_ldi", ELdi, ret);
    ret = ret + 1'b1;

    // Timeout in IF -> ERR, absorbing
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) step("to_wait", EIfWait, ret);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step("to_err", BBerr, ret);

    // Reset out of ERR
    rst = 1'b0;
    step("err_rst", BBerr, ret);
    rst = 1'b1; sticky = '0; ret = '0; mem_ready = 1'b0;
    step("err_after_rst", EIfWait, ret);

    // LDI then STM interrupted by reset in STM_WR
    mem_ready = 1'b1;
    step("ldi2_if", EIfRdy, ret); step("ldi2_dec", EDec, ret); step("ldi2_ex", ELdi, ret);
    ret = ret + 1'b1;
    instruction = 4'b1001;
    step("stm2_if", EIfRdy, ret);
    step("stm2_dec", EDec, ret);
    step("stm2_maddr", EMaddr, ret);
    mem_ready = 1'b0;
    step("stm2_wait", EStmWr, ret);
    rst = 1'b0;
    step("stm2_rst", EStmWr, ret);
    rst = 1'b1; ret = '0;
    step("stm2_after_rst", EIfWait, ret);

    // HLT: counted on entry to HALT, then no strobes regardless of inputs
    instruction = 4'b1111; mem_ready = 1'b1;
    step("hlt_if", EIfRdy, ret);
    step("hlt_dec", EDec, ret);
    ret = ret + 1'b1;
    instruction = 4'b0011;
    step("hlt_halt0", BHalt, ret);
    mem_ready = 1'b0;
    step("hlt_halt1", BHalt, ret);
    mem_ready = 1'b1;
    step("hlt_halt2", BHalt, ret);

    // Reset out of HALT
    rst = 1'b0;
    step("hlt_rst", BHalt, ret);
    rst = 1'b1; ret = '0; mem_ready = 1'b0;
    step("hlt_after_rst", EIfWait, ret);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
